// File: rtl/stream_dispatch_pkg.sv
// Shared definitions for the stream dispatcher: destination codes and dest-field position helpers.
// The merge side uses the same helpers to find the dest field.
package stream_dispatch_pkg;

    typedef enum logic [1:0] {
        DEST_A = 2'b00,
        DEST_B = 2'b01,
        DEST_C = 2'b10,
        DEST_X = 2'b11
    } dest_e;

    // The destination field sits in the two MSBs of every word.
    function automatic int destMsb(input int width);
        return width - 1;
    endfunction

    function automatic int destLsb(input int width);
        return width - 2;
    endfunction

endpackage

// File: rtl/stream_dispatch_if.sv
// Handshake bundle for the dispatcher: one input stream (D), three output channels (A/B/C), drop count.
interface stream_dispatch_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             i_DataValid_D;
    logic [WIDTH-1:0] i_DataIn_D;
    logic             o_DataGrant_D;

    logic             i_DataGrant_A, i_DataGrant_B, i_DataGrant_C;
    logic             o_DataValid_A, o_DataValid_B, o_DataValid_C;
    logic [WIDTH-1:0] o_DataOut_A, o_DataOut_B, o_DataOut_C;
    logic [CNT_W-1:0] o_DropCnt;

    modport slave (
        input  i_DataValid_D, i_DataIn_D, i_DataGrant_A, i_DataGrant_B, i_DataGrant_C,
        output o_DataGrant_D, o_DataValid_A, o_DataValid_B, o_DataValid_C,
               o_DataOut_A, o_DataOut_B, o_DataOut_C, o_DropCnt
    );

    modport master (
        output i_DataValid_D, i_DataIn_D, i_DataGrant_A, i_DataGrant_B, i_DataGrant_C,
        input  o_DataGrant_D, o_DataValid_A, o_DataValid_B, o_DataValid_C,
               o_DataOut_A, o_DataOut_B, o_DataOut_C, o_DropCnt
    );
endinterface

// File: rtl/stream_dispatch_fifo.sv
// dispatch_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers.
// Head reads 0 while empty so the channel output is clean straight out of reset.
module dispatch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr, rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush, doPop;

    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty  = (wrPtr == rdPtr);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign head   = empty ? '0 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/stream_dispatch.sv
// stream_dispatch: steers one input stream to three per-channel FWFT FIFOs by the word's dest field.
// DISPATCH_BROADCAST_EN: dest 11 goes to all three channels instead of being dropped and counted.
module stream_dispatch
    import stream_dispatch_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    stream_dispatch_if.slave bus
);
    dest_e dest;
    logic  fullA, fullB, fullC;
    logic  emptyA, emptyB, emptyC;
    logic  selA, selB, selC;
    logic  grant, accept;

    assign dest = dest_e'(bus.i_DataIn_D[destMsb(WIDTH):destLsb(WIDTH)]);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        selA  = 1'b0;
        selB  = 1'b0;
        selC  = 1'b0;
        grant = 1'b0;
        case (dest)
            DEST_A: begin selA = 1'b1; grant = ~fullA; end
            DEST_B: begin selB = 1'b1; grant = ~fullB; end
            DEST_C: begin selC = 1'b1; grant = ~fullC; end
            DEST_X: begin
`ifdef DISPATCH_BROADCAST_EN
                selA  = 1'b1;
                selB  = 1'b1;
                selC  = 1'b1;
                grant = ~fullA & ~fullB & ~fullC;
`else
                grant = 1'b1;
`endif
            end
            default: grant = 1'b0;
        endcase
        if (Reset) grant = 1'b0;
    end

    assign accept            = bus.i_DataValid_D & grant;
    assign bus.o_DataGrant_D = grant;

`ifdef DISPATCH_BROADCAST_EN
    assign bus.o_DropCnt = '0;
`else
    logic [CNT_W-1:0] dropCnt;

    // Saturates rather than wraps so a long run of bad words never reads as few.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            dropCnt <= '0;
        end else if (accept && dest == DEST_X && dropCnt != '1) begin
            dropCnt <= dropCnt + CNT_W'(1);
        end
    end

    assign bus.o_DropCnt = dropCnt;
`endif

    dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_FifoA (
        .CLK(CLK), .Reset(Reset), .push(accept & selA), .pop(bus.i_DataGrant_A),
        .wrData(bus.i_DataIn_D), .full(fullA), .empty(emptyA), .head(bus.o_DataOut_A)
    );

    dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_FifoB (
        .CLK(CLK), .Reset(Reset), .push(accept & selB), .pop(bus.i_DataGrant_B),
        .wrData(bus.i_DataIn_D), .full(fullB), .empty(emptyB), .head(bus.o_DataOut_B)
    );

    dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_FifoC (
        .CLK(CLK), .Reset(Reset), .push(accept & selC), .pop(bus.i_DataGrant_C),
        .wrData(bus.i_DataIn_D), .full(fullC), .empty(emptyC), .head(bus.o_DataOut_C)
    );

    assign bus.o_DataValid_A = ~emptyA;
    assign bus.o_DataValid_B = ~emptyB;
    assign bus.o_DataValid_C = ~emptyC;

endmodule

// File: tb/tb_stream_dispatch.sv
// Scoreboard bench for stream_dispatch: stimulus pushes expected words per channel, a monitor pops them.
// Uses a 4-bit drop counter so saturation is reachable in a few words.
module tb_stream_dispatch;
    localparam int WIDTH = 64;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
`ifdef DISPATCH_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        int               edgeNo;
    } exp_t;

    logic CLK;
    logic Reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   strictLat;
    exp_t qA[$], qB[$], qC[$];

    stream_dispatch_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    stream_dispatch #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at the negedge before the accepting edge, hence edgeNo = cyc + 1.
    task automatic pushExp(input logic [WIDTH-1:0] w);
        exp_t e;
        e.data   = w;
        e.edgeNo = cyc + 1;
        case (w[63:62])
            2'b00: qA.push_back(e);
            2'b01: qB.push_back(e);
            2'b10: qC.push_back(e);
            default: if (BCAST) begin
                qA.push_back(e);
                qB.push_back(e);
                qC.push_back(e);
            end
        endcase
    endtask

    task automatic monChan(input int ch, input logic v, input logic g, input logic [WIDTH-1:0] d);
        exp_t e;
        string nm;
        int    sz;
        nm = (ch == 0) ? "A" : (ch == 1) ? "B" : "C";
        sz = (ch == 0) ? qA.size() : (ch == 1) ? qB.size() : qC.size();
        if (v && g) begin
            if (sz == 0) begin
                check({"spurious_", nm}, v, 0);
            end else begin
                if (ch == 0)      e = qA.pop_front();
                else if (ch == 1) e = qB.pop_front();
                else              e = qC.pop_front();
                check({"data_", nm}, d, e.data);
                if (strictLat) check({"latency_", nm}, cyc - e.edgeNo, 0);
                else           check({"noBypass_", nm}, cyc >= e.edgeNo, 1);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                monChan(0, bus.o_DataValid_A, bus.i_DataGrant_A, bus.o_DataOut_A);
                monChan(1, bus.o_DataValid_B, bus.i_DataGrant_B, bus.o_DataOut_B);
                monChan(2, bus.o_DataValid_C, bus.i_DataGrant_C, bus.o_DataOut_C);
            end
        end
    end

    task automatic sendWord(input logic [WIDTH-1:0] w);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        bus.i_DataValid_D = 1'b1;
        bus.i_DataIn_D    = w;
        while (!done && n < 300) begin
            @(negedge CLK);
            if (bus.o_DataGrant_D) begin
                pushExp(w);
                done = 1'b1;
            end
            n++;
            @(posedge CLK);
            #1;
        end
        bus.i_DataValid_D = 1'b0;
        check("accepted", done, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qA.size() + qB.size() + qC.size()) != 0 && n < 500) begin
            @(posedge CLK);
            n++;
        end
        check("drained", qA.size() + qB.size() + qC.size(), 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        strictLat = 1'b0;
        Reset     = 1'b1;
        bus.i_DataValid_D = 1'b1;
        bus.i_DataIn_D    = 64'h0;
        bus.i_DataGrant_A = 1'b1;
        bus.i_DataGrant_B = 1'b1;
        bus.i_DataGrant_C = 1'b1;

        // Reset state, with a valid word already presented
        #12;
        check("rst_grantD", bus.o_DataGrant_D, 0);
        check("rst_validA", bus.o_DataValid_A, 0);
        check("rst_validB", bus.o_DataValid_B, 0);
        check("rst_validC", bus.o_DataValid_C, 0);
        check("rst_dataA", bus.o_DataOut_A, 0);
        check("rst_dataC", bus.o_DataOut_C, 0);
        check("rst_drop", bus.o_DropCnt, 0);
        bus.i_DataValid_D = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;

        // 1: one word per channel on consecutive edges, exact one-edge latency
        strictLat = 1'b1;
        sendWord(64'h0000_0000_0000_00AA);
        sendWord(64'h4000_0000_0000_00BB);
        sendWord(64'h8000_0000_0000_00CC);
        drain();
        strictLat = 1'b0;

        // 2: fill A, B still flows, 9th A waits until one edge after the first pop
        bus.i_DataGrant_A = 1'b0;
        for (int i = 0; i < 8; i++) sendWord(64'h0000_0000_0000_0A00 | 64'(i));
        sendWord(64'h4000_0000_0000_0B01);
        bus.i_DataValid_D = 1'b1;
        bus.i_DataIn_D    = 64'h0000_0000_0000_0A08;
        @(negedge CLK);
        check("full_grantD", bus.o_DataGrant_D, 0);
        check("full_validA", bus.o_DataValid_A, 1);
        @(posedge CLK);
        #1;
        bus.i_DataGrant_A = 1'b1;
        @(negedge CLK);
        check("popEdge_grantD", bus.o_DataGrant_D, 0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("afterPop_grantD", bus.o_DataGrant_D, 1);
        pushExp(bus.i_DataIn_D);
        @(posedge CLK);
        #1;
        bus.i_DataValid_D = 1'b0;
        drain();

        // 3: 20 B words with a toggling consumer, crossing the pointer wrap
        bus.i_DataGrant_B = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) sendWord(64'h4000_0000_0000_1000 | 64'(i));
            end
            begin
                repeat (80) begin
                    @(posedge CLK);
                    #1;
                    bus.i_DataGrant_B = ~bus.i_DataGrant_B;
                end
            end
        join
        bus.i_DataGrant_B = 1'b1;
        drain();

        // 4: dest 11 is dropped and counted (or broadcast), counter saturates
        strictLat = 1'b1;
        @(negedge CLK);
        bus.i_DataIn_D = 64'hC000_0000_0000_00DD;
        check("destX_grantD", bus.o_DataGrant_D, 1);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) sendWord(64'hC000_0000_0000_00D0 | 64'(i));
        drain();
        check("drop_3", bus.o_DropCnt, BCAST ? 0 : 3);
        for (int i = 0; i < 11; i++) sendWord(64'hC000_0000_0000_00E0 | 64'(i));
        drain();
        check("drop_14", bus.o_DropCnt, BCAST ? 0 : 14);
        for (int i = 0; i < 4; i++) sendWord(64'hC000_0000_0000_00F0 | 64'(i));
        drain();
        check("drop_sat", bus.o_DropCnt, BCAST ? 0 : 15);
        strictLat = 1'b0;

        // 5: reset mid-stream with 4 words parked in C
        bus.i_DataGrant_C = 1'b0;
        for (int i = 0; i < 4; i++) sendWord(64'h8000_0000_0000_0C00 | 64'(i));
        @(negedge CLK);
        check("parked_validC", bus.o_DataValid_C, 1);
        #2;
        Reset = 1'b1;
        #1;
        check("asyncRst_validC", bus.o_DataValid_C, 0);
        check("asyncRst_dataC", bus.o_DataOut_C, 0);
        check("asyncRst_drop", bus.o_DropCnt, 0);
        qC.delete();
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check("postRst_validC", bus.o_DataValid_C, 0);
        bus.i_DataGrant_C = 1'b1;
        sendWord(64'h8000_0000_0000_0C55);
        drain();

        // 6: count-1 FIFO with push and pop on the same edge
        bus.i_DataGrant_A = 1'b0;
        sendWord(64'h0000_0000_0000_0111);
        @(negedge CLK);
        check("cnt1_head", bus.o_DataOut_A, 64'h0000_0000_0000_0111);
        @(posedge CLK);
        #1;
        bus.i_DataGrant_A = 1'b1;
        bus.i_DataValid_D = 1'b1;
        w = 64'h0000_0000_0000_0222;
        bus.i_DataIn_D = w;
        @(negedge CLK);
        check("cnt1_grantD", bus.o_DataGrant_D, 1);
        pushExp(w);
        @(posedge CLK);
        #1;
        bus.i_DataValid_D = 1'b0;
        bus.i_DataGrant_A = 1'b0;
        @(negedge CLK);
        check("cnt1_validA", bus.o_DataValid_A, 1);
        check("cnt1_newHead", bus.o_DataOut_A, w);
        @(posedge CLK);
        #1;
        bus.i_DataGrant_A = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
